// File: rtl/afifo_wr_burst_arb.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : afifo_wr_burst_arb                                               |
// | Brief    : round-robin per-burst arbiter for the async FIFO write port.     |
// |            Optional stall watchdog enabled by AFIFO_WR_ARB_WDOG_EN.         |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module afifo_wr_burst_arb #(
   parameter int N_CH     = 4,
   parameter int DW       = 64,
   parameter int LEN_W    = 8,
   parameter int WDOG_CYC = 1024
) (
   input  logic                    wr_clk,
   input  logic                    wr_rst_n,
   input  logic [N_CH-1:0]         ch_req,
   input  logic [N_CH*LEN_W-1:0]   ch_len,
   input  logic [N_CH*DW-1:0]      ch_data,
   input  logic [N_CH-1:0]         ch_dvld,
   output logic [N_CH-1:0]         ch_gnt,
   output logic [N_CH-1:0]         ch_drdy,
   output logic                    fifo_wr_en,
   output logic [DW-1:0]           fifo_wr_data,
   input  logic                    fifo_wr_vld,
   output logic [$clog2(N_CH)-1:0] cur_ch,
   output logic                    busy,
   output logic                    burst_done,
   output logic                    wdog_err
);
   localparam int         CW     = $clog2(N_CH);
   localparam logic [0:0] C_IDLE = 1'b0;
   localparam logic [0:0] C_XFER = 1'b1;

   logic [0:0]       r_state;
   logic [N_CH-1:0]  r_gnt;
   logic [CW-1:0]    r_cur_ch;
   logic [CW-1:0]    r_rr_ptr;
   logic [LEN_W-1:0] r_beat_cnt;
   logic             r_done;
   logic             r_wdog;

   logic             w_fire;
   logic             w_last;
   logic             w_abort;
   logic [CW-1:0]    w_sel;
   logic [N_CH-1:0]  w_sel_oh;
   logic [N_CH-1:0]  w_drdy;

   assign busy         = (r_state == C_XFER);
   assign w_fire       = busy & ch_dvld[r_cur_ch] & fifo_wr_vld;
   assign w_last       = w_fire && (r_beat_cnt == '0);
   assign fifo_wr_en   = w_fire;
   assign fifo_wr_data = ch_data[int'(r_cur_ch)*DW +: DW];
   assign ch_drdy      = w_drdy;
   assign ch_gnt       = r_gnt;
   assign cur_ch       = r_cur_ch;
   assign burst_done   = r_done;
   assign wdog_err     = r_wdog;

   // Scan from the farthest candidate to the nearest so the first requester after r_rr_ptr wins.
   always_comb begin
      w_sel = '0;
      for (int i = N_CH; i >= 1; i--) begin
         if (ch_req[(int'(r_rr_ptr) + i) % N_CH]) begin
            w_sel = CW'((int'(r_rr_ptr) + i) % N_CH);
         end
      end
   end

   always_comb begin
      w_sel_oh        = '0;
      w_sel_oh[w_sel] = 1'b1;
   end

   always_comb begin
      w_drdy = '0;
      if (w_fire) begin
         w_drdy[r_cur_ch] = 1'b1;
      end
   end

`ifdef AFIFO_WR_ARB_WDOG_EN
   localparam int SW = $clog2(WDOG_CYC);

   logic [SW-1:0] r_stall_cnt;

   // Only a silent source counts; FIFO backpressure freezes the count.
   assign w_abort = busy && !w_fire && (r_stall_cnt == SW'(WDOG_CYC - 1));

   always_ff @(posedge wr_clk or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         r_stall_cnt <= '0;
      end else if (!busy || w_fire) begin
         r_stall_cnt <= '0;
      end else if (!ch_dvld[r_cur_ch] && !w_abort) begin
         r_stall_cnt <= r_stall_cnt + SW'(1);
      end
   end
`else
   // No watchdog: WDOG_CYC >= 2 keeps this term constant 0.
   assign w_abort = busy && (WDOG_CYC < 2);
`endif

   always_ff @(posedge wr_clk or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         r_state    <= C_IDLE;
         r_gnt      <= '0;
         r_rr_ptr   <= CW'(N_CH - 1);
         r_cur_ch   <= '0;
         r_beat_cnt <= '0;
         r_done     <= 1'b0;
         r_wdog     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_wdog <= 1'b0;
         case (r_state)
            C_IDLE: begin
               if (|ch_req) begin
                  r_state    <= C_XFER;
                  r_gnt      <= w_sel_oh;
                  r_cur_ch   <= w_sel;
                  r_beat_cnt <= ch_len[int'(w_sel)*LEN_W +: LEN_W];
               end
            end
            default: begin
               if (w_last) begin
                  r_state  <= C_IDLE;
                  r_rr_ptr <= r_cur_ch;
                  r_gnt    <= '0;
                  r_done   <= 1'b1;
               end else if (w_fire) begin
                  r_beat_cnt <= r_beat_cnt - LEN_W'(1);
               end else if (w_abort) begin
                  r_state  <= C_IDLE;
                  r_rr_ptr <= r_cur_ch;
                  r_gnt    <= '0;
                  r_wdog   <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_afifo_wr_burst_arb.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_afifo_wr_burst_arb                                            |
// | Brief    : scoreboard bench; queue-based round-robin model vs. FIFO beats.  |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module tb_afifo_wr_burst_arb;
   localparam int N_CH     = 4;
   localparam int DW       = 64;
   localparam int LEN_W    = 8;
   localparam int WDOG_CYC = 16;
   localparam int CW       = $clog2(N_CH);

   logic                  wr_clk;
   logic                  wr_rst_n;
   logic [N_CH-1:0]       ch_req;
   logic [N_CH*LEN_W-1:0] ch_len;
   logic [N_CH*DW-1:0]    ch_data;
   logic [N_CH-1:0]       ch_dvld;
   logic [N_CH-1:0]       ch_gnt;
   logic [N_CH-1:0]       ch_drdy;
   logic                  fifo_wr_en;
   logic [DW-1:0]         fifo_wr_data;
   logic                  fifo_wr_vld;
   logic [CW-1:0]         cur_ch;
   logic                  busy;
   logic                  burst_done;
   logic                  wdog_err;

   afifo_wr_burst_arb #(
      .N_CH(N_CH), .DW(DW), .LEN_W(LEN_W), .WDOG_CYC(WDOG_CYC)
   ) dut (
      .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .ch_req(ch_req), .ch_len(ch_len),
      .ch_data(ch_data), .ch_dvld(ch_dvld), .ch_gnt(ch_gnt), .ch_drdy(ch_drdy),
      .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_wr_vld(fifo_wr_vld),
      .cur_ch(cur_ch), .busy(busy), .burst_done(burst_done), .wdog_err(wdog_err)
   );

   initial wr_clk = 1'b0;
   always #5 wr_clk = ~wr_clk;

   typedef struct {
      int            ch;
      logic [DW-1:0] data;
      bit            last;
   } beat_t;

   beat_t         exp_q[$];
   int            len_q   [N_CH][$];
   logic [DW-1:0] src_q   [N_CH][$];
   int            mdl_len [N_CH][$];
   logic [DW-1:0] mdl_dat [N_CH][$];
   int            mdl_ptr;

   int checks, passes, wdog_seen, beats_seen;
   bit rand_mode, vld_low, stall_en, req_all;
   int stall_ch;
   logic [N_CH-1:0] smp_drdy, smp_gnt, prev_gnt;

   task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Source side: each channel owns queued burst lengths and beat data.
   task automatic add_burst(input int c, input int len, input bit to_model);
      logic [DW-1:0] d;
      len_q[c].push_back(len);
      if (to_model) mdl_len[c].push_back(len);
      for (int b = 0; b <= len; b++) begin
         d = {c[7:0], b[7:0], 16'($urandom), 32'($urandom)};
         src_q[c].push_back(d);
         if (to_model) mdl_dat[c].push_back(d);
      end
   endtask

   // Reference: serve pending bursts in round-robin order after the last granted channel.
   task automatic commit();
      bit    more;
      int    c, len;
      beat_t e;
      more = 1'b1;
      while (more) begin
         more = 1'b0;
         c    = 0;
         for (int k = 1; k <= N_CH; k++) begin
            if (!more && mdl_len[(mdl_ptr + k) % N_CH].size() > 0) begin
               c    = (mdl_ptr + k) % N_CH;
               more = 1'b1;
            end
         end
         if (more) begin
            len = mdl_len[c].pop_front();
            for (int b = 0; b <= len; b++) begin
               e.ch   = c;
               e.data = mdl_dat[c].pop_front();
               e.last = (b == len);
               exp_q.push_back(e);
            end
            mdl_ptr = c;
         end
      end
   endtask

   function automatic bit any_pending();
      bit p = 1'b0;
      for (int c = 0; c < N_CH; c++) if (len_q[c].size() > 0) p = 1'b1;
      return p;
   endfunction

   task automatic drive_inputs();
      for (int c = 0; c < N_CH; c++) begin
         ch_req[c]                 = req_all || (len_q[c].size() > 0);
         ch_len[c*LEN_W +: LEN_W]  = (len_q[c].size() > 0) ? LEN_W'(len_q[c][0]) : '0;
         ch_data[c*DW +: DW]       = (src_q[c].size() > 0) ? src_q[c][0] : '0;
         ch_dvld[c]                = (src_q[c].size() > 0) && !(stall_en && c == stall_ch) &&
                                     (!rand_mode || $urandom_range(0, 9) < 7);
      end
      fifo_wr_vld = !vld_low && (!rand_mode || $urandom_range(0, 3) != 0);
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      while ((exp_q.size() > 0 || busy || any_pending()) && n < budget) begin
         @(negedge wr_clk);
         n++;
      end
      check_eq({name, "_complete"}, 64'(n < budget), 64'(1));
      repeat (2) @(negedge wr_clk);
   endtask

   // Driver: handshakes seen at the negedge take effect after the following posedge.
   initial begin
      prev_gnt = '0;
      forever begin
         @(negedge wr_clk);
         smp_drdy = ch_drdy;
         smp_gnt  = ch_gnt;
         @(posedge wr_clk);
         #1;
         if (wr_rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
               if (smp_gnt[c] && !prev_gnt[c] && len_q[c].size() > 0) void'(len_q[c].pop_front());
               if (smp_drdy[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
            end
            prev_gnt = smp_gnt;
         end else begin
            prev_gnt = '0;
         end
         drive_inputs();
      end
   end

   // Monitor: every FIFO write is popped from the expected queue and compared.
   initial begin
      bit    exp_done;
      beat_t e;
      exp_done = 1'b0;
      forever begin
         @(negedge wr_clk);
         if (!wr_rst_n) begin
            exp_done = 1'b0;
         end else begin
            if (exp_done || burst_done) begin
               check_eq("burst_done", 64'(burst_done), 64'(exp_done));
               if (exp_done) check_eq("gap_busy", 64'(busy), 64'(0));
            end
            exp_done = 1'b0;
            if (wdog_err) wdog_seen++;
            if (fifo_wr_en) begin
               beats_seen++;
               if (exp_q.size() == 0) begin
                  check_eq("unexpected_wr_en", 64'(fifo_wr_en), 64'(0));
               end else begin
                  e = exp_q.pop_front();
                  check_eq("beat_ch", 64'(cur_ch), 64'(e.ch));
                  check_eq("beat_data", 64'(fifo_wr_data), 64'(e.data));
                  check_eq("beat_drdy", 64'(ch_drdy), 64'(1) << e.ch);
                  check_eq("beat_gnt", 64'(ch_gnt), 64'(1) << e.ch);
                  exp_done = e.last;
               end
            end else if (busy) begin
               check_eq("stall_drdy", 64'(ch_drdy), 64'(0));
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      int n, start;
      checks = 0; passes = 0; wdog_seen = 0; beats_seen = 0;
      rand_mode = 0; vld_low = 0; stall_en = 0; req_all = 1; stall_ch = 0;
      mdl_ptr = N_CH - 1;
      wr_rst_n = 1'b0;
      ch_req = '1; ch_len = '0; ch_data = '0; ch_dvld = '0; fifo_wr_vld = 1'b0;

      // Reset held with every channel requesting
      repeat (4) @(negedge wr_clk);
      check_eq("rst_gnt", 64'(ch_gnt), 64'(0));
      check_eq("rst_wr_en", 64'(fifo_wr_en), 64'(0));
      check_eq("rst_busy", 64'(busy), 64'(0));
      check_eq("rst_done", 64'(burst_done), 64'(0));
      check_eq("rst_wdog", 64'(wdog_err), 64'(0));
      check_eq("rst_drdy", 64'(ch_drdy), 64'(0));
      check_eq("rst_cur_ch", 64'(cur_ch), 64'(0));
      req_all = 0;
      repeat (2) @(negedge wr_clk);
      #2 wr_rst_n = 1'b1;
      @(negedge wr_clk);

      // All channels, single-beat bursts: ch0,ch1,ch2,ch3,ch0
      add_burst(0, 0, 1); add_burst(1, 0, 1); add_burst(2, 0, 1);
      add_burst(3, 0, 1); add_burst(0, 0, 1);
      commit();
      wait_idle(200, "rr_all");

      // Single 4-beat burst on ch0
      add_burst(0, 3, 1);
      commit();
      @(posedge wr_clk); #2;
      check_eq("single_gnt_early", 64'(ch_gnt), 64'(0));
      @(posedge wr_clk); #2;
      check_eq("single_gnt", 64'(ch_gnt), 64'(4'b0001));
      for (int i = 0; i < 4; i++) begin
         @(negedge wr_clk);
         check_eq("single_consec_wr_en", 64'(fifo_wr_en), 64'(1));
      end
      wait_idle(100, "single");

      // FIFO backpressure in the middle of an 8-beat burst
      start = beats_seen;
      add_burst(1, 7, 1);
      commit();
      n = 0;
      while (beats_seen - start < 3 && n < 100) begin @(negedge wr_clk); n++; end
      vld_low = 1;
      @(posedge wr_clk); #2;
      for (int i = 0; i < 5; i++) begin
         @(negedge wr_clk);
         check_eq("bp_wr_en", 64'(fifo_wr_en), 64'(0));
         check_eq("bp_drdy", 64'(ch_drdy), 64'(0));
      end
      vld_low = 0;
      wait_idle(100, "bp");
      check_eq("bp_beat_total", 64'(beats_seen - start), 64'(8));

      // Asynchronous reset in the middle of a burst
      start = beats_seen;
      add_burst(2, 7, 1);
      commit();
      n = 0;
      while (beats_seen - start < 3 && n < 100) begin @(negedge wr_clk); n++; end
      #2 wr_rst_n = 1'b0;
      #1;
      check_eq("arst_gnt", 64'(ch_gnt), 64'(0));
      check_eq("arst_busy", 64'(busy), 64'(0));
      check_eq("arst_wr_en", 64'(fifo_wr_en), 64'(0));
      check_eq("arst_cur_ch", 64'(cur_ch), 64'(0));
      exp_q.delete();
      for (int c = 0; c < N_CH; c++) begin
         len_q[c].delete();
         src_q[c].delete();
      end
      mdl_ptr = N_CH - 1;
      repeat (2) @(negedge wr_clk);
      #2 wr_rst_n = 1'b1;
      @(negedge wr_clk);
      add_burst(1, 2, 1); add_burst(0, 1, 1); add_burst(3, 0, 1);
      commit();
      n = 0;
      while (!busy && n < 50) begin @(negedge wr_clk); n++; end
      check_eq("arst_first_gnt", 64'(ch_gnt), 64'(4'b0001));
      wait_idle(200, "arst");

      // Source stops supplying beats while granted
      stall_ch = 2;
      stall_en = 1;
`ifdef AFIFO_WR_ARB_WDOG_EN
      add_burst(2, 3, 0);
      add_burst(3, 0, 1);
      commit();
      n = 0;
      while (!ch_gnt[2] && n < 50) begin @(negedge wr_clk); n++; end
      n = 0;
      while (!wdog_err && n < 100) begin @(negedge wr_clk); n++; end
      check_eq("wdog_latency", 64'(n), 64'(WDOG_CYC));
      check_eq("wdog_idle", 64'(busy), 64'(0));
      src_q[2].delete();
      stall_en = 0;
      wait_idle(100, "wdog");
      check_eq("wdog_pulses", 64'(wdog_seen), 64'(1));
`else
      add_burst(2, 3, 1);
      commit();
      n = 0;
      while (!busy && n < 50) begin @(negedge wr_clk); n++; end
      repeat (40) @(negedge wr_clk);
      check_eq("hold_gnt", 64'(ch_gnt), 64'(4'b0100));
      check_eq("hold_busy", 64'(busy), 64'(1));
      check_eq("hold_wdog", 64'(wdog_err), 64'(0));
      stall_en = 0;
      wait_idle(100, "hold");
      check_eq("hold_wdog_pulses", 64'(wdog_seen), 64'(0));
`endif

      // Randomized traffic, including one maximum-length burst
      rand_mode = 1;
      for (int r = 0; r < 3; r++) begin
         if (r == 0) add_burst(3, 255, 1);
         for (int i = 0; i < 8; i++) begin
            add_burst(int'($urandom_range(0, N_CH - 1)), int'($urandom_range(0, 12)), 1);
         end
         commit();
         wait_idle(4000, "random");
      end
      rand_mode = 0;

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
